cte_yuv2rgb: RTL

Receive-side colour transform for the CTE datapath: consumes the serial 4:2:2 byte stream U, Y0, V, Y1 and reconstructs two 24-bit RGB pixels per group. This is the inverse of the RGB-to-YUV function, which emits exactly this stream. It sits between the byte-wide YUV source and the pixel sink, and is checked against the same golden YUV/RGB pattern files.

---
 rtl/cte_pkg.sv | 18 +
 rtl/cte_clamp8.sv | 16 +
 rtl/cte_yuv2rgb.sv | 109 ++++++++++
 3 files changed

// File: rtl/cte_pkg.sv
// Shared constants for the CTE colour transform: byte phase encoding and Q8 chroma coefficients.
package cte_pkg;

  typedef enum logic [1:0] {
    PH_U  = 2'd0,
    PH_Y0 = 2'd1,
    PH_V  = 2'd2,
    PH_Y1 = 2'd3
  } phase_t;

  localparam logic signed [17:0] C_RV  = 18'sd359;
  localparam logic signed [17:0] C_GU  = 18'sd88;
  localparam logic signed [17:0] C_GV  = 18'sd183;
  localparam logic signed [17:0] C_BU  = 18'sd454;
  localparam logic signed [17:0] C_RND = 18'sd128;
  localparam int unsigned        Q_SHIFT = 8;

endpackage

// File: rtl/cte_clamp8.sv
// Saturates a signed 11-bit channel sum to unsigned 0..255; purely combinational.
module cte_clamp8 (
  input  logic signed [10:0] din,
  output logic        [7:0]  dout
);

  always_comb begin
    dout = din[7:0];
    if (din[10]) begin
      dout = 8'd0;
    end else if (din > 11'sd255) begin
      dout = 8'hFF;
    end
  end

endmodule

// File: rtl/cte_yuv2rgb.sv
// 4:2:2 byte stream (U,Y0,V,Y1) to two RGB888 pixels; pixel valid one edge after its completing byte.
// busy only during reset and one cycle after; otherwise accepts one byte per cycle with no stall.
module cte_yuv2rgb
  import cte_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [7:0]  yuv_in,
  output logic        busy,
  output logic        out_valid,
  output logic [23:0] rgb_out
);

  phase_t            phase;
  logic [7:0]        u_q;
  logic [7:0]        y0_q;
  logic              accept;
  logic signed [17:0] u_s;
  logic signed [17:0] v_s;
  logic signed [10:0] tr_c;
  logic signed [10:0] tg_c;
  logic signed [10:0] tb_c;

  logic              vld_a;
  logic [7:0]        y_a;
  logic signed [10:0] tr_a;
  logic signed [10:0] tg_a;
  logic signed [10:0] tb_a;

  logic signed [10:0] y_ext;
  logic signed [10:0] r_s;
  logic signed [10:0] g_s;
  logic signed [10:0] b_s;
  logic [7:0]        r_c;
  logic [7:0]        g_c;
  logic [7:0]        b_c;

  assign accept = in_en && !busy;

  // Chroma terms fit comfortably in 11 bits; the 18-bit products are only needed before the shift.
  assign u_s  = 18'($signed(u_q));
  assign v_s  = 18'($signed(yuv_in));
  assign tr_c = 11'((C_RV * v_s + C_RND) >>> Q_SHIFT);
  assign tg_c = 11'((C_GU * u_s + C_GV * v_s + C_RND) >>> Q_SHIFT);
  assign tb_c = 11'((C_BU * u_s + C_RND) >>> Q_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy  <= 1'b1;
      phase <= PH_U;
      u_q   <= 8'd0;
      y0_q  <= 8'd0;
    end else begin
      busy <= 1'b0;
      if (accept) begin
        case (phase)
          PH_U:    u_q  <= yuv_in;
          PH_Y0:   y0_q <= yuv_in;
          default: ;
        endcase
        phase <= phase_t'(phase + 2'd1);
      end
    end
  end

  // Stage A: the Y1 pixel reuses the chroma terms registered with the V byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_a <= 1'b0;
      y_a   <= 8'd0;
      tr_a  <= 11'sd0;
      tg_a  <= 11'sd0;
      tb_a  <= 11'sd0;
    end else begin
      vld_a <= accept && (phase == PH_V || phase == PH_Y1);
      if (accept && phase == PH_V) begin
        y_a  <= y0_q;
        tr_a <= tr_c;
        tg_a <= tg_c;
        tb_a <= tb_c;
      end else if (accept && phase == PH_Y1) begin
        y_a <= yuv_in;
      end
    end
  end

  assign y_ext = $signed({3'b000, y_a});
  assign r_s   = y_ext + tr_a;
  assign g_s   = y_ext - tg_a;
  assign b_s   = y_ext + tb_a;

  cte_clamp8 u_clamp_r (.din(r_s), .dout(r_c));
  cte_clamp8 u_clamp_g (.din(g_s), .dout(g_c));
  cte_clamp8 u_clamp_b (.din(b_s), .dout(b_c));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      rgb_out   <= 24'h000000;
    end else begin
      out_valid <= vld_a;
      if (vld_a) begin
        rgb_out <= {r_c, g_c, b_c};
      end
    end
  end

endmodule
